// File: rtl/icache_ctrl.sv
// icache_ctrl: instruction-cache controller for a 32-set x 64-bit direct-mapped
// cache memory (8-byte lines, idx = addr[7:3], tag = addr[15:8]).
// Serves hits combinationally through the cache memory. On a miss it issues one
// LOAD to instruction memory, waits for the matching transaction tag and writes
// the returned line through the cache memory's single write port.
// Optional feature macro: ICACHE_FORWARD_EN. When it is defined, the fill line
// is forwarded to fetch in the fill cycle if fetch is requesting that line.
module icache_ctrl (
  input  logic        clock,
  input  logic        reset,              // asynchronous, active-low

  // Fetch side
  input  logic [63:0] proc2Icache_addr,
  input  logic        proc2Icache_req,
  output logic [63:0] Icache_data_out,
  output logic        Icache_valid_out,

  // Cache memory read port
  output logic [4:0]  rd_idx,
  output logic [7:0]  rd_tag,
  input  logic [63:0] cachemem_data,
  input  logic        cachemem_valid,

  // Cache memory write port
  output logic        wr_en,
  output logic [4:0]  wr_idx,
  output logic [7:0]  wr_tag,
  output logic [63:0] wr_data,

  // Instruction memory
  output logic [1:0]  proc2Imem_command,
  output logic [63:0] proc2Imem_addr,
  input  logic [3:0]  Imem2proc_response,
  input  logic [63:0] Imem2proc_data,
  input  logic [3:0]  Imem2proc_tag
);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e      state_q,     state_d;
  logic [12:0] miss_addr_q, miss_addr_d;   // line address bits [15:3]
  logic [3:0]  mem_tag_q,   mem_tag_d;

  logic        fill_match;
  logic [12:0] fetch_line;

  // Address bits outside the 16-bit cacheable window carry no information here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{proc2Icache_addr[63:16], proc2Icache_addr[2:0]};

  assign fetch_line = proc2Icache_addr[15:3];

  // Read index/tag straight from the fetch address (zero-latency hit path).
  assign rd_idx = proc2Icache_addr[7:3];
  assign rd_tag = proc2Icache_addr[15:8];

  // A return matches only in WAIT. mem_tag is never zero there, but checking it
  // also keeps a stale return from matching right after reset clears mem_tag.
  assign fill_match = (state_q == S_WAIT) &&
                      (mem_tag_q != 4'd0) &&
                      (Imem2proc_tag == mem_tag_q);

  // Write port: index/tag from the latched miss, data straight from memory.
  assign wr_idx  = miss_addr_q[4:0];
  assign wr_tag  = miss_addr_q[12:5];
  assign wr_data = Imem2proc_data;

  // Hit path, with optional same-cycle forwarding of the fill line.
  always_comb begin
    Icache_data_out  = cachemem_data;
    Icache_valid_out = proc2Icache_req && cachemem_valid;
`ifdef ICACHE_FORWARD_EN
    if (fill_match && proc2Icache_req && (fetch_line == miss_addr_q)) begin
      Icache_data_out  = Imem2proc_data;
      Icache_valid_out = 1'b1;
    end
`endif
  end

  // Miss FSM: next state, latched miss/transaction info and memory-side outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so that
    // no path through the case statement leaves a value held (no latch).
    state_d           = state_q;
    miss_addr_d       = miss_addr_q;
    mem_tag_d         = mem_tag_q;
    proc2Imem_command = CMD_NONE;
    proc2Imem_addr    = 64'd0;
    wr_en             = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (proc2Icache_req && !cachemem_valid) begin
          miss_addr_d = fetch_line;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        proc2Imem_command = CMD_LOAD;
        proc2Imem_addr    = {48'd0, miss_addr_q, 3'b000};
        // A zero response means the LOAD was not accepted; re-issue next cycle.
        if (Imem2proc_response != 4'd0) begin
          mem_tag_d = Imem2proc_response;
          state_d   = S_WAIT;
        end
      end

      S_WAIT: begin
        // Redirects are ignored here: the fill always completes for miss_addr.
        if (fill_match) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears the FSM and forgets any outstanding tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      miss_addr_q <= 13'd0;
      mem_tag_q   <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      mem_tag_q   <= mem_tag_d;
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed self-checking bench for icache_ctrl. A small
// direct-mapped cache memory model sits on the read/write ports; expected
// values are hand-computed from the fetch/memory stimulus.
module tb_icache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] proc2Icache_addr;
  logic        proc2Icache_req;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic [4:0]  rd_idx;
  logic [7:0]  rd_tag;
  logic [63:0] cachemem_data;
  logic        cachemem_valid;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [7:0]  wr_tag;
  logic [63:0] wr_data;
  logic [1:0]  proc2Imem_command;
  logic [63:0] proc2Imem_addr;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] DATA_A = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] DATA_B = 64'h1111_2222_3333_4444;
  localparam logic [63:0] DATA_C = 64'hAAAA_5555_AAAA_5555;
  localparam logic [63:0] DATA_D = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DATA_E = 64'hFEED_F00D_CAFE_0007;

`ifdef ICACHE_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  icache_ctrl dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Icache_addr   (proc2Icache_addr),
    .proc2Icache_req    (proc2Icache_req),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .rd_idx             (rd_idx),
    .rd_tag             (rd_tag),
    .cachemem_data      (cachemem_data),
    .cachemem_valid     (cachemem_valid),
    .wr_en              (wr_en),
    .wr_idx             (wr_idx),
    .wr_tag             (wr_tag),
    .wr_data            (wr_data),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag)
  );

  always #5 clock = ~clock;

  // Cache memory model: 32 sets, valid/tag/data, write on rising edge.
  logic        flush;
  logic        m_valid [32];
  logic [7:0]  m_tag   [32];
  logic [63:0] m_data  [32];

  always @(posedge clock) begin
    if (flush) begin
      for (int i = 0; i < 32; i++) m_valid[i] <= 1'b0;
    end else if (wr_en) begin
      m_valid[wr_idx] <= 1'b1;
      m_tag[wr_idx]   <= wr_tag;
      m_data[wr_idx]  <= wr_data;
    end
  end

  always_comb begin
    cachemem_valid = m_valid[rd_idx] && (m_tag[rd_idx] == rd_tag);
    cachemem_data  = m_data[rd_idx];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int waited;

    reset              = 1'b0;
    flush              = 1'b1;
    proc2Icache_addr   = 64'd0;
    proc2Icache_req    = 1'b0;
    Imem2proc_response = 4'd0;
    Imem2proc_data     = 64'd0;
    Imem2proc_tag      = 4'd0;
    tick();
    tick();
    flush = 1'b0;

    // Reset state
    check("rst_cmd",   64'(proc2Imem_command), 64'd0);
    check("rst_maddr", proc2Imem_addr,         64'd0);
    check("rst_wr_en", 64'(wr_en),             64'd0);
    check("rst_valid", 64'(Icache_valid_out),  64'd0);

    // Reset asserted mid-WAIT, then a stale return with tag 3
    reset = 1'b1;
    tick();
    proc2Icache_addr = 64'h5000;
    proc2Icache_req  = 1'b1;
    check("rd_idx_5000", 64'(rd_idx), 64'd0);
    check("rd_tag_5000", 64'(rd_tag), 64'h50);
    tick();
    check("r1_cmd_load", 64'(proc2Imem_command), 64'd1);
    check("r1_addr",     proc2Imem_addr,         64'h5000);
    Imem2proc_response = 4'd3;
    tick();
    Imem2proc_response = 4'd0;
    proc2Icache_req    = 1'b0;
    check("r1_wait_cmd", 64'(proc2Imem_command), 64'd0);
    reset = 1'b0;
    #1;
    check("r1_rst_cmd", 64'(proc2Imem_command), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("r1_idle_cmd", 64'(proc2Imem_command), 64'd0);
    Imem2proc_tag  = 4'd3;
    Imem2proc_data = DATA_E;
    #1;
    check("r1_stale_wr", 64'(wr_en), 64'd0);
    tick();
    Imem2proc_tag = 4'd0;
    check("r1_stale_wr2", 64'(wr_en), 64'd0);

    // Cold miss at 0x1238: response 2 at once, tag 2 three cycles later
    proc2Icache_addr = 64'h1238;
    proc2Icache_req  = 1'b1;
    #1;
    check("c_miss_valid", 64'(Icache_valid_out), 64'd0);
    check("c_rd_idx",     64'(rd_idx),           64'd7);
    tick();
    check("c_cmd_load", 64'(proc2Imem_command), 64'd1);
    check("c_addr",     proc2Imem_addr,         64'h1238);
    Imem2proc_response = 4'd2;
    tick();
    Imem2proc_response = 4'd0;
    check("c_wait_cmd", 64'(proc2Imem_command), 64'd0);
    check("c_wait_wr",  64'(wr_en),             64'd0);
    tick();
    tick();
    Imem2proc_tag  = 4'd2;
    Imem2proc_data = DATA_A;
    #1;
    check("c_wr_en",   64'(wr_en),            64'd1);
    check("c_wr_idx",  64'(wr_idx),           64'd7);
    check("c_wr_tag",  64'(wr_tag),           64'h12);
    check("c_wr_data", wr_data,               DATA_A);
    check("c_fwd_vld", 64'(Icache_valid_out), 64'(FWD));
    if (FWD) check("c_fwd_data", Icache_data_out, DATA_A);
    tick();
    Imem2proc_tag  = 4'd0;
    Imem2proc_data = 64'd0;
    #1;
    check("c_wr_once",  64'(wr_en),             64'd0);
    check("c_hit_vld",  64'(Icache_valid_out),  64'd1);
    check("c_hit_data", Icache_data_out,        DATA_A);
    check("c_hit_cmd",  64'(proc2Imem_command), 64'd0);

    // Response 0 for 4 cycles then 5; tag 4 ignored, tag 5 fills idx 3
    proc2Icache_addr = 64'h3418;
    tick();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("h_load_%0d", i), 64'(proc2Imem_command), 64'd1);
      Imem2proc_response = (i == 4) ? 4'd5 : 4'd0;
      tick();
    end
    Imem2proc_response = 4'd0;
    check("h_wait_cmd", 64'(proc2Imem_command), 64'd0);
    Imem2proc_tag  = 4'd4;
    Imem2proc_data = DATA_C;
    #1;
    check("h_tag4_wr", 64'(wr_en), 64'd0);
    tick();
    Imem2proc_tag  = 4'd5;
    Imem2proc_data = DATA_B;
    #1;
    check("h_tag5_wr",  64'(wr_en),  64'd1);
    check("h_tag5_idx", 64'(wr_idx), 64'd3);
    check("h_tag5_tag", 64'(wr_tag), 64'h34);
    tick();
    Imem2proc_tag = 4'd0;
    check("h_hit_data", Icache_data_out,       DATA_B);
    check("h_hit_vld",  64'(Icache_valid_out), 64'd1);

    // Hit at idx 7 while a miss for idx 3 (0x5518) is in WAIT
    proc2Icache_addr = 64'h5518;
    #1;
    check("w_miss_vld", 64'(Icache_valid_out), 64'd0);
    tick();
    Imem2proc_response = 4'd6;
    tick();
    Imem2proc_response = 4'd0;
    proc2Icache_addr   = 64'h1238;
    #1;
    check("w_hit_vld",  64'(Icache_valid_out),  64'd1);
    check("w_hit_data", Icache_data_out,        DATA_A);
    check("w_hit_cmd",  64'(proc2Imem_command), 64'd0);
    Imem2proc_tag  = 4'd6;
    Imem2proc_data = DATA_D;
    #1;
    check("w_fill_wr",   64'(wr_en),            64'd1);
    check("w_fill_idx",  64'(wr_idx),           64'd3);
    check("w_fill_tag",  64'(wr_tag),           64'h55);
    check("w_fill_hit",  64'(Icache_valid_out), 64'd1);
    check("w_fill_data", Icache_data_out,       DATA_A);
    tick();
    Imem2proc_tag = 4'd0;

    // Redirect to 0x2000 while in WAIT for 0x1238 (idx 7 flushed first)
    proc2Icache_req = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    proc2Icache_addr = 64'h1238;
    proc2Icache_req  = 1'b1;
    #1;
    check("d_miss_vld", 64'(Icache_valid_out), 64'd0);
    tick();
    check("d_addr", proc2Imem_addr, 64'h1238);
    Imem2proc_response = 4'd7;
    tick();
    Imem2proc_response = 4'd0;
    proc2Icache_addr   = 64'h2000;
    tick();
    check("d_no_new_load", 64'(proc2Imem_command), 64'd0);
    Imem2proc_tag  = 4'd7;
    Imem2proc_data = DATA_E;
    #1;
    check("d_fill_wr",   64'(wr_en),            64'd1);
    check("d_fill_idx",  64'(wr_idx),           64'd7);
    check("d_fill_tag",  64'(wr_tag),           64'h12);
    check("d_fill_data", wr_data,               DATA_E);
    check("d_fill_vld",  64'(Icache_valid_out), 64'd0);
    tick();
    Imem2proc_tag = 4'd0;
    waited = 0;
    while (proc2Imem_command != 2'd1 && waited < 4) begin
      tick();
      waited++;
    end
    check("d_new_load", 64'(proc2Imem_command), 64'd1);
    check("d_new_addr", proc2Imem_addr,         64'h2000);
    Imem2proc_response = 4'd8;
    tick();
    Imem2proc_response = 4'd0;
    Imem2proc_tag      = 4'd8;
    Imem2proc_data     = DATA_C;
    #1;
    check("d_new_fill_idx", 64'(wr_idx), 64'd0);
    check("d_new_fill_tag", 64'(wr_tag), 64'h20);
    tick();
    Imem2proc_tag = 4'd0;
    check("d_new_hit", Icache_data_out, DATA_C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
